// File: rtl/lmsm_if.sv
// lmsm_if: controller/memory-side bundle for the LM/SM sequencer
interface lmsm_if #(
  parameter int ADDR_W = 16,
  parameter int LIST_W = 8
);
  localparam int SEL_W = $clog2(LIST_W);
  localparam int CNT_W = $clog2(LIST_W + 1);
  logic              start;
  logic              is_store;
  logic [LIST_W-1:0] reg_list;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic              rf_we;
  logic [SEL_W-1:0]  reg_sel;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  xfer_count;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_data;
  modport master (
    output start, is_store, reg_list, base_addr, mem_ready,
    input  mem_addr, mem_re, mem_we, rf_we, reg_sel, busy, done, xfer_count, wb_en, wb_data
  );
  modport slave (
    input  start, is_store, reg_list, base_addr, mem_ready,
    output mem_addr, mem_re, mem_we, rf_we, reg_sel, busy, done, xfer_count, wb_en, wb_data
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: walks an LM/SM register list lowest-bit-first, one word per transfer.
// Define LMSM_WRITEBACK_EN to drive wb_en/wb_data (base + transfers) in the DONE cycle.
module lmsm_sequencer #(
  parameter int ADDR_W = 16,
  parameter int LIST_W = 8
) (
  input logic   clk,
  input logic   proc_rst,
  lmsm_if.slave bus
);
  localparam int SEL_W = $clog2(LIST_W);
  localparam int CNT_W = $clog2(LIST_W + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t            state, state_n;
  logic [LIST_W-1:0] pending, rest;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  count;
  logic              store;
  logic [SEL_W-1:0]  low;
  logic              acc, take;
  assign rest = pending & (pending - LIST_W'(1));
  assign acc  = state == ACCESS;
  assign take = state == IDLE && bus.start;
  always_comb begin
    low = '0;
    for (int i = LIST_W - 1; i >= 0; i--) low = pending[i] ? SEL_W'(i) : low;
  end
  always_ff @(posedge clk) state <= !proc_rst ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE   ? (bus.start ? (bus.reg_list != '0 ? ACCESS : DONE) : IDLE) :
              state == ACCESS ? (bus.mem_ready && rest == '0 ? DONE : ACCESS) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!proc_rst) begin
      pending <= '0;
      addr    <= '0;
      count   <= '0;
      store   <= 1'b0;
    end else if (take) begin
      pending <= bus.reg_list;
      addr    <= bus.base_addr;
      count   <= '0;
      store   <= bus.is_store;
    end else if (acc && bus.mem_ready) begin
      pending <= rest;
      addr    <= addr + ADDR_W'(1);
      count   <= count + CNT_W'(1);
    end
  end
  always_comb begin
    bus.busy       = acc;
    bus.done       = state == DONE;
    bus.mem_addr   = acc ? addr : '0;
    bus.mem_we     = acc & store;
    bus.mem_re     = acc & ~store;
    bus.rf_we      = acc & ~store & bus.mem_ready;
    bus.reg_sel    = acc ? low : '0;
    bus.xfer_count = count;
  end
`ifdef LMSM_WRITEBACK_EN
  logic [ADDR_W-1:0] base;
  always_ff @(posedge clk) base <= !proc_rst ? '0 : take ? bus.base_addr : base;
  assign bus.wb_en   = state == DONE;
  assign bus.wb_data = state == DONE ? base + ADDR_W'(count) : '0;
`else
  assign bus.wb_en   = 1'b0;
  assign bus.wb_data = '0;
`endif
endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: directed LM/SM sequences checked against a transfer-queue model every cycle
module tb_lmsm_sequencer;
  logic clk = 1'b0;
  logic proc_rst = 1'b0;
  always #5 clk = ~clk;
  lmsm_if bus ();
  lmsm_sequencer dut (.clk(clk), .proc_rst(proc_rst), .bus(bus));
`ifdef LMSM_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif
  typedef struct {int sel; int addr;} xfer_t;
  xfer_t q[$];
  bit m_done = 1'b0, m_store = 1'b0, chk_en = 1'b0;
  int m_cnt = 0, m_base = 0;
  int vectors = 0, miscompares = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: a start expands the list into its full (reg, addr) schedule; each ready cycle retires one entry.
  always @(posedge clk) begin
    if (!proc_rst) begin
      q.delete();
      m_done = 1'b0;
      m_cnt  = 0;
    end else if (m_done) m_done = 1'b0;
    else if (q.size() > 0) begin
      if (bus.mem_ready) begin
        void'(q.pop_front());
        m_cnt++;
        m_done = q.size() == 0;
      end
    end else if (bus.start) begin
      int a;
      logic [7:0] l;
      l = bus.reg_list;
      m_base = int'(bus.base_addr);
      m_store = bus.is_store;
      m_cnt = 0;
      a = m_base;
      for (int i = 0; i < 8; i++)
        if (l[i]) begin
          q.push_back('{i, a});
          a = (a + 1) & 16'hFFFF;
        end
      m_done = q.size() == 0;
    end
  end
  always @(negedge clk) if (chk_en) begin
    bit act;
    act = q.size() > 0;
    check("busy", bus.busy, act);
    check("done", bus.done, m_done);
    check("mem_addr", bus.mem_addr, act ? q[0].addr : 0);
    check("reg_sel", bus.reg_sel, act ? q[0].sel : 0);
    check("mem_we", bus.mem_we, act && m_store);
    check("mem_re", bus.mem_re, act && !m_store);
    check("rf_we", bus.rf_we, act && !m_store && bus.mem_ready);
    check("xfer_count", bus.xfer_count, m_cnt);
    check("wb_en", bus.wb_en, WB && m_done);
    check("wb_data", bus.wb_data, (WB && m_done) ? ((m_base + m_cnt) & 16'hFFFF) : 0);
  end
  task automatic do_start(input bit st, input logic [7:0] list, input logic [15:0] base);
    bus.is_store  = st;
    bus.reg_list  = list;
    bus.base_addr = base;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask
  initial begin
    logic [7:0] lists [3] = '{8'h5A, 8'h81, 8'h3C};
    bus.start = 1'b0; bus.is_store = 1'b0; bus.reg_list = '0; bus.base_addr = '0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_cnt", bus.xfer_count, 0);
    @(posedge clk); #1 proc_rst = 1'b1;
    bus.mem_ready = 1'b1;
    do_start(1'b1, 8'h05, 16'h0100);
    @(negedge clk);
    check("sm05_sel0", bus.reg_sel, 0); check("sm05_addr0", bus.mem_addr, 16'h0100); check("sm05_we0", bus.mem_we, 1);
    @(posedge clk); @(negedge clk);
    check("sm05_sel1", bus.reg_sel, 2); check("sm05_addr1", bus.mem_addr, 16'h0101);
    @(posedge clk); @(negedge clk);
    check("sm05_done", bus.done, 1); check("sm05_cnt", bus.xfer_count, 2);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    do_start(1'b0, 8'h80, 16'h0040);
    repeat (3) begin
      @(negedge clk);
      check("lm80_re", bus.mem_re, 1); check("lm80_rfwe_wait", bus.rf_we, 0); check("lm80_sel", bus.reg_sel, 7);
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("lm80_rfwe", bus.rf_we, 1); check("lm80_addr", bus.mem_addr, 16'h0040);
    @(posedge clk); @(negedge clk);
    check("lm80_done", bus.done, 1);
    @(posedge clk); #1;
    do_start(1'b0, 8'h00, 16'h1234);
    @(negedge clk);
    check("empty_done", bus.done, 1); check("empty_re", bus.mem_re, 0); check("empty_cnt", bus.xfer_count, 0);
    check("empty_wb", bus.wb_data, WB ? 32'h1234 : 32'h0);
    @(posedge clk); #1;
    do_start(1'b0, 8'hFF, 16'hFFFE);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("ff_sel", bus.reg_sel, i); check("ff_addr", bus.mem_addr, (16'hFFFE + i) & 16'hFFFF);
      @(posedge clk);
    end
    @(negedge clk);
    check("ff_done", bus.done, 1); check("ff_cnt", bus.xfer_count, 8); check("ff_wb", bus.wb_data, WB ? 32'h6 : 32'h0);
    @(posedge clk); #1;
    do_start(1'b1, 8'h0F, 16'h0300);
    @(negedge clk); check("rst_seq_sel0", bus.reg_sel, 0);
    @(posedge clk); #1 proc_rst = 1'b0;
    @(negedge clk); check("rst_seq_sel1", bus.reg_sel, 1);
    @(posedge clk); #1 proc_rst = 1'b1;
    @(negedge clk);
    check("abort_busy", bus.busy, 0); check("abort_we", bus.mem_we, 0); check("abort_cnt", bus.xfer_count, 0);
    @(posedge clk); #1;
    do_start(1'b1, 8'h0F, 16'h0300);
    @(negedge clk); check("restart_sel", bus.reg_sel, 0); check("restart_addr", bus.mem_addr, 16'h0300);
    repeat (4) @(posedge clk);
    @(negedge clk); check("restart_done", bus.done, 1); check("restart_cnt", bus.xfer_count, 4);
    @(posedge clk); #1;
    do_start(1'b0, 8'h03, 16'h0200);
    bus.start = 1'b1; bus.reg_list = 8'hF0;
    @(negedge clk); check("ign_sel0", bus.reg_sel, 0);
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk); check("ign_sel1", bus.reg_sel, 1);
    @(posedge clk); @(negedge clk); check("ign_done", bus.done, 1); check("ign_cnt", bus.xfer_count, 2);
    @(posedge clk); @(negedge clk); check("ign_idle", bus.busy, 0); check("ign_hold", bus.xfer_count, 2);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      bus.mem_ready = 1'b0;
      do_start(k[0], lists[k], 16'(16'hFFF0 + k * 5));
      while (!bus.done && n < 60) begin
        @(posedge clk); #1;
        n++;
        bus.mem_ready = (n % 3) != 0;
      end
      check("wait_done_seen", bus.done, 1);
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
